// File: rtl/truth_table_sweeper.sv
// Exhaustive 3-input sweep engine: drives {a,b,c}=0..7, settles, samples y,
// compares against EXPECTED and reports per-vector log plus summary results.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 5,
  parameter logic [7:0]  EXPECTED      = 8'b1110_1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_count,
  output logic       first_fail_valid,
  output logic [2:0] first_fail_vec,
  output logic       log_valid,
  output logic [2:0] log_vec,
  output logic       log_y,
  output logic       log_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] mm_q, mm_d;
  logic       ffv_q, ffv_d;
  logic [2:0] ffvec_q, ffvec_d;
  logic       logv_q, logv_d;
  logic [2:0] logvec_q, logvec_d;
  logic       logy_q, logy_d;
  logic       logerr_q, logerr_d;

  logic       err_s;
  logic [3:0] mm_inc_s;

  assign err_s    = y ^ EXPECTED[idx_q];
  assign mm_inc_s = mm_q + {3'b000, err_s};

  // Next-state and next-output logic for the sweep FSM
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mm_d     = mm_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    logv_d   = 1'b0;
    logvec_d = logvec_q;
    logy_d   = logy_q;
    logerr_d = logerr_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = 3'd0;
          cnt_d   = RELOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          mm_d    = 4'd0;
          ffv_d   = 1'b0;
          ffvec_d = 3'd0;
        end else begin
          state_d = state_q;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SAMPLE: begin
        logv_d   = 1'b1;
        logvec_d = idx_q;
        logy_d   = y;
        logerr_d = err_s;
        mm_d     = mm_inc_s;
        if (err_s && !ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = idx_q;
        end else begin
          ffv_d   = ffv_q;
        end
        // Vector 7 ends the sweep; idx is never advanced past it
        if (idx_q == 3'd7) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (mm_inc_s == 4'd0);
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + 3'd1;
          cnt_d   = RELOAD;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      cnt_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mm_q     <= 4'd0;
      ffv_q    <= 1'b0;
      ffvec_q  <= 3'd0;
      logv_q   <= 1'b0;
      logvec_q <= 3'd0;
      logy_q   <= 1'b0;
      logerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mm_q     <= mm_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      logv_q   <= logv_d;
      logvec_q <= logvec_d;
      logy_q   <= logy_d;
      logerr_q <= logerr_d;
    end
  end

  assign a                = idx_q[2];
  assign b                = idx_q[1];
  assign c                = idx_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mm_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign log_valid        = logv_q;
  assign log_vec          = logvec_q;
  assign log_y            = logy_q;
  assign log_err          = logerr_q;

endmodule
